// File: rtl/pbox_inv_buf_if.sv
// pbox_inv_buf_if: valid/ready stream bundle for the inverse-P buffer
interface pbox_inv_buf_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/pbox_inv_buf.sv
// pbox_inv_buf: inverse DES P permutation with 2-entry buffer; PBOX_INV_SELFCHECK_EN adds forward-P check
module pbox_inv_buf #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pbox_inv_buf_if.slave    bus,
    output logic [CNT_W-1:0] word_cnt,
    output logic             chk_err
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    localparam logic [4:0] M [32] = '{11, 17, 5, 27, 25, 10, 20, 0, 13, 21, 3, 28, 29, 7, 18, 24,
                                      31, 22, 12, 6, 26, 2, 16, 8, 14, 30, 4, 19, 1, 9, 15, 23};
    state_t      state;
    logic [31:0] head;
    logic [31:0] tail;
    logic [31:0] inv;
    logic        acc;
    logic        pop;
    assign acc = bus.in_valid & bus.in_ready;
    assign pop = bus.out_valid & bus.out_ready;
    assign bus.out_data = head;
    for (genvar j = 0; j < 32; j++) begin : g_inv
        assign inv[j] = bus.in_data[M[j]];
    end
    // occupancy FSM; words are stored already inverted, head drives out_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            head          <= '0;
            tail          <= '0;
            word_cnt      <= '0;
        end else begin
            if (acc) word_cnt <= word_cnt + CNT_W'(1);
            if (flush) begin
                state         <= EMPTY;
                bus.in_ready  <= 1'b1;
                bus.out_valid <= 1'b0;
                head          <= '0;
                tail          <= '0;
            end else begin
                case (state)
                    EMPTY: if (acc) begin
                        head          <= inv;
                        state         <= ONE;
                        bus.out_valid <= 1'b1;
                    end
                    ONE: if (acc && !pop) begin
                        tail         <= inv;
                        state        <= FULL;
                        bus.in_ready <= 1'b0;
                    end else if (acc) begin
                        head <= inv;
                    end else if (pop) begin
                        state         <= EMPTY;
                        bus.out_valid <= 1'b0;
                    end
                    FULL: if (pop) begin
                        head         <= tail;
                        state        <= ONE;
                        bus.in_ready <= 1'b1;
                    end
                    default: begin
                        state         <= EMPTY;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end
`ifdef PBOX_INV_SELFCHECK_EN
    localparam logic [4:0] S [32] = '{16, 25, 12, 11, 3, 20, 4, 15, 31, 17, 9, 6, 27, 14, 1, 22,
                                      30, 24, 8, 18, 0, 5, 29, 23, 13, 19, 2, 26, 10, 21, 28, 7};
    logic [31:0] fwd;
    for (genvar k = 0; k < 32; k++) begin : g_fwd
        assign fwd[31-k] = inv[S[k]];
    end
    // sticky flag when re-permuting the inverse does not reproduce the input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_err <= 1'b0;
        else if (acc && fwd != bus.in_data) chk_err <= 1'b1;
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_pbox_inv_buf.sv
// tb_pbox_inv_buf: vector table, scoreboard and corner-case sequences for pbox_inv_buf
module tb_pbox_inv_buf;
    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt4;
    logic        chk_err;
    logic        chk_err4;
    int          checks;
    int          failures;
    logic [31:0] exp_cnt;
    logic [31:0] c0;
    logic [31:0] exp_q [$];
    vec_t        v [6];
    pbox_inv_buf_if ifc ();
    pbox_inv_buf_if if4 ();
    assign if4.in_data   = ifc.in_data;
    assign if4.in_valid  = ifc.in_valid;
    assign if4.out_ready = ifc.out_ready;
    pbox_inv_buf #(.CNT_W(16)) u (.clk(clk), .rst(rst), .flush(flush), .bus(ifc), .word_cnt(word_cnt), .chk_err(chk_err));
    pbox_inv_buf #(.CNT_W(4)) u4 (.clk(clk), .rst(rst), .flush(flush), .bus(if4), .word_cnt(word_cnt4), .chk_err(chk_err4));
    function automatic logic [31:0] pinv(input logic [31:0] x);
        int m [32] = '{11, 17, 5, 27, 25, 10, 20, 0, 13, 21, 3, 28, 29, 7, 18, 24,
                       31, 22, 12, 6, 26, 2, 16, 8, 14, 30, 4, 19, 1, 9, 15, 23};
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[m[i]];
        return r;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    // scoreboard: push expected inverse on accept, compare head on pop
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            if (ifc.in_valid && ifc.in_ready) exp_cnt++;
            if (flush) exp_q.delete();
            else begin
                if (ifc.out_valid && ifc.out_ready) begin
                    if (exp_q.size() == 0) check("sb_pop_empty", 32'd1, 32'd0);
                    else check("sb_data", ifc.out_data, exp_q.pop_front());
                end
                if (ifc.in_valid && ifc.in_ready) exp_q.push_back(pinv(ifc.in_data));
            end
        end
    end
    initial begin
        checks = 0;
        failures = 0;
        exp_cnt = 0;
        v[0] = '{32'h0000_0001, 32'h0000_0080};
        v[1] = '{32'h8000_0000, 32'h0001_0000};
        v[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[3] = '{32'h0000_0000, 32'h0000_0000};
        v[4] = '{32'h0000_0800, 32'h0000_0001};
        v[5] = '{32'h0000_0080, 32'h0000_2000};
        rst = 1;
        flush = 0;
        ifc.in_valid = 0;
        ifc.in_data = 0;
        ifc.out_ready = 0;
        repeat (2) tick;
        rst = 0;
        @(negedge clk);
        check("rst_out_valid", 32'(ifc.out_valid), 0);
        check("rst_in_ready", 32'(ifc.in_ready), 1);
        check("rst_out_data", ifc.out_data, 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_chk_err", 32'(chk_err), 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            ifc.in_valid = 1;
            ifc.in_data = v[i].d;
            ifc.out_ready = 1;
            tick;
            ifc.in_valid = 0;
            @(negedge clk);
            check("vec_valid", 32'(ifc.out_valid), 1);
            check("vec_data", ifc.out_data, v[i].e);
            check("vec_cnt", 32'(word_cnt), 32'(i + 1));
            tick;
            @(negedge clk);
            check("vec_drained", 32'(ifc.out_valid), 0);
        end
        tick;
        ifc.out_ready = 0;
        ifc.in_valid = 1;
        ifc.in_data = 32'h0000_0001;
        tick;
        ifc.in_data = 32'h8000_0000;
        tick;
        ifc.in_valid = 0;
        @(negedge clk);
        check("bp_full_ready", 32'(ifc.in_ready), 0);
        check("bp_head", ifc.out_data, 32'h0000_0080);
        repeat (3) tick;
        @(negedge clk);
        check("bp_hold", ifc.out_data, 32'h0000_0080);
        check("bp_hold_valid", 32'(ifc.out_valid), 1);
        tick;
        ifc.out_ready = 1;
        @(negedge clk);
        check("bp_first", ifc.out_data, 32'h0000_0080);
        tick;
        @(negedge clk);
        check("bp_second", ifc.out_data, 32'h0001_0000);
        check("bp_ready_back", 32'(ifc.in_ready), 1);
        tick;
        @(negedge clk);
        check("bp_empty", 32'(ifc.out_valid), 0);
        c0 = exp_cnt;
        tick;
        ifc.out_ready = 0;
        ifc.in_valid = 1;
        ifc.in_data = $urandom;
        tick;
        ifc.out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            ifc.in_data = $urandom;
            @(negedge clk);
            check("one_valid", 32'(ifc.out_valid), 1);
            check("one_ready", 32'(ifc.in_ready), 1);
            tick;
        end
        ifc.in_valid = 0;
        @(negedge clk);
        check("one_cnt", 32'(word_cnt), 32'(16'(c0 + 21)));
        repeat (2) tick;
        @(negedge clk);
        check("one_drained", 32'(ifc.out_valid), 0);
        ifc.out_ready = 0;
        ifc.in_valid = 1;
        ifc.in_data = $urandom;
        tick;
        ifc.in_data = $urandom;
        tick;
        tick;
        flush = 1;
        ifc.in_data = $urandom;
        c0 = exp_cnt;
        tick;
        flush = 0;
        ifc.in_valid = 0;
        @(negedge clk);
        check("flush_full_valid", 32'(ifc.out_valid), 0);
        check("flush_full_ready", 32'(ifc.in_ready), 1);
        check("flush_full_cnt", 32'(word_cnt), 32'(16'(c0)));
        tick;
        ifc.in_valid = 1;
        ifc.in_data = $urandom;
        tick;
        flush = 1;
        ifc.in_data = $urandom;
        c0 = exp_cnt;
        tick;
        flush = 0;
        ifc.in_valid = 0;
        @(negedge clk);
        check("flush_one_valid", 32'(ifc.out_valid), 0);
        check("flush_one_cnt", 32'(word_cnt), 32'(16'(c0 + 1)));
        tick;
        ifc.out_ready = 0;
        ifc.in_valid = 1;
        ifc.in_data = $urandom;
        tick;
        ifc.in_data = $urandom;
        tick;
        ifc.in_data = $urandom;
        #2 rst = 1;
        #1;
        check("arst_out_valid", 32'(ifc.out_valid), 0);
        check("arst_in_ready", 32'(ifc.in_ready), 1);
        check("arst_out_data", ifc.out_data, 0);
        check("arst_cnt", 32'(word_cnt), 0);
        ifc.in_valid = 0;
        tick;
        rst = 0;
        ifc.out_ready = 1;
        ifc.in_valid = 1;
        for (int k = 0; k < 17; k++) begin
            ifc.in_data = $urandom;
            tick;
        end
        ifc.in_valid = 0;
        @(negedge clk);
        check("cnt4_wrap", 32'(word_cnt4), 1);
        check("cnt16", 32'(word_cnt), 17);
        tick;
        for (int k = 0; k < 300; k++) begin
            ifc.in_valid = 1'($urandom_range(0, 1));
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            ifc.in_data = $urandom;
            tick;
        end
        ifc.in_valid = 0;
        ifc.out_ready = 1;
        repeat (4) tick;
        @(negedge clk);
        check("rand_drained", 32'(ifc.out_valid), 0);
        check("rand_queue", 32'(exp_q.size()), 0);
        check("rand_cnt", 32'(word_cnt), 32'(exp_cnt[15:0]));
        check("chk_err_clear", 32'(chk_err), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
